// File: rtl/cfg_reg_bank_if.sv
// Select/ack request bus of the configuration register bank.
interface cfg_reg_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              sel_en;
  logic              wr_rd_s;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ack;
  logic              err;

  modport master (
    output sel_en, wr_rd_s, addr, wr_data,
    input  rd_data, ack, err
  );

  modport slave (
    input  sel_en, wr_rd_s, addr, wr_data,
    output rd_data, ack, err
  );
endinterface

// File: rtl/cfg_reg_bank.sv
// Configuration register bank with select/ack access and parallel export on mem_out.
// Optional CFG_REG_SHADOW_EN: writes land in a shadow array, copied to mem_out on commit.
module cfg_reg_bank #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 8,
  parameter int                NUM_OF_REG = 4,
  parameter logic [DATA_W-1:0] RST_VAL    = {DATA_W{1'b0}},
  parameter int                WAIT_CYC   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef CFG_REG_SHADOW_EN
  input  logic                         commit,
`endif
  cfg_reg_bank_if.slave                bus,
  output logic [NUM_OF_REG*DATA_W-1:0] mem_out
);

  localparam int IDX_W = (NUM_OF_REG > 1) ? $clog2(NUM_OF_REG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              wr_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              ack_r;
  logic              err_r;

  logic [DATA_W-1:0] act_r [NUM_OF_REG];
  logic [IDX_W-1:0]  idx_s;
  logic              in_range_s;
  logic              fire_s;
  logic              wr_en_s;
  logic [DATA_W-1:0] rd_src_s;

  // Decode of the captured request and the registering-edge strobe.
  always_comb begin
    idx_s      = addr_r[IDX_W-1:0];
    // Extra top bit keeps the compare exact when NUM_OF_REG == 2**ADDR_W.
    in_range_s = ({1'b0, addr_r} < (ADDR_W+1)'(NUM_OF_REG));
    if ((state_r == ST_WAIT) && bus.sel_en && (cnt_r == 4'(WAIT_CYC))) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
    wr_en_s = fire_s && wr_r && in_range_s;
  end

`ifdef CFG_REG_SHADOW_EN
  logic [DATA_W-1:0] shd_r   [NUM_OF_REG];
  logic [DATA_W-1:0] shd_nxt_s [NUM_OF_REG];

  // Shadow array with the pending write merged in, so a coinciding commit sees it.
  always_comb begin
    shd_nxt_s = shd_r;
    if (wr_en_s) begin
      shd_nxt_s[idx_s] = wdata_r;
    end else begin
      shd_nxt_s = shd_r;
    end
    rd_src_s = shd_r[idx_s];
  end

  // Shadow and active arrays; commit copies the whole shadow image.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OF_REG; i++) begin
        shd_r[i] <= RST_VAL;
        act_r[i] <= RST_VAL;
      end
    end else begin
      shd_r <= shd_nxt_s;
      if (commit) begin
        act_r <= shd_nxt_s;
      end
    end
  end
`else
  // Read source is the active array itself.
  always_comb begin
    rd_src_s = act_r[idx_s];
  end

  // Active register array, written directly on the registering edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OF_REG; i++) begin
        act_r[i] <= RST_VAL;
      end
    end else if (wr_en_s) begin
      act_r[idx_s] <= wdata_r;
    end
  end
`endif

  // Access FSM: capture, wait/abort, one-cycle response, hold until release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      rd_data_r <= {DATA_W{1'b0}};
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack_r     <= 1'b0;
          err_r     <= 1'b0;
          rd_data_r <= {DATA_W{1'b0}};
          if (bus.sel_en) begin
            wr_r    <= bus.wr_rd_s;
            addr_r  <= bus.addr;
            wdata_r <= bus.wr_data;
            cnt_r   <= 4'd0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.sel_en) begin
            state_r <= ST_IDLE;
          end else if (fire_s) begin
            state_r   <= ST_RESP;
            ack_r     <= 1'b1;
            err_r     <= !in_range_s;
            rd_data_r <= (!wr_r && in_range_s) ? rd_src_s : {DATA_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          ack_r     <= 1'b0;
          err_r     <= 1'b0;
          rd_data_r <= {DATA_W{1'b0}};
          state_r   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.sel_en) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          ack_r     <= 1'b0;
          err_r     <= 1'b0;
          rd_data_r <= {DATA_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.ack     = ack_r;
  assign bus.err     = err_r;
  assign bus.rd_data = rd_data_r;

  for (genvar g = 0; g < NUM_OF_REG; g++) begin : g_mem_out
    assign mem_out[g*DATA_W +: DATA_W] = act_r[g];
  end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Directed bench for cfg_reg_bank: one instance with WAIT_CYC=0, one with WAIT_CYC=3.
module tb_cfg_reg_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tb_sel, tb_which, tb_wr, tb_commit;
  logic [7:0] tb_addr, tb_wdata;
  logic [31:0] mem0, mem3;
  logic       ack_m, err_m;
  logic [7:0] rd_m;

  cfg_reg_bank_if #(.DATA_W(8), .ADDR_W(8)) bus0 ();
  cfg_reg_bank_if #(.DATA_W(8), .ADDR_W(8)) bus3 ();

  assign bus0.sel_en  = tb_sel && !tb_which;
  assign bus0.wr_rd_s = tb_wr;
  assign bus0.addr    = tb_addr;
  assign bus0.wr_data = tb_wdata;
  assign bus3.sel_en  = tb_sel && tb_which;
  assign bus3.wr_rd_s = tb_wr;
  assign bus3.addr    = tb_addr;
  assign bus3.wr_data = tb_wdata;

  assign ack_m = tb_which ? bus3.ack     : bus0.ack;
  assign err_m = tb_which ? bus3.err     : bus0.err;
  assign rd_m  = tb_which ? bus3.rd_data : bus0.rd_data;

  cfg_reg_bank #(.DATA_W(8), .ADDR_W(8), .NUM_OF_REG(4), .RST_VAL(8'h00), .WAIT_CYC(0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef CFG_REG_SHADOW_EN
    .commit  (tb_commit),
`endif
    .bus     (bus0),
    .mem_out (mem0)
  );

  cfg_reg_bank #(.DATA_W(8), .ADDR_W(8), .NUM_OF_REG(4), .RST_VAL(8'h00), .WAIT_CYC(3)) u_dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef CFG_REG_SHADOW_EN
    .commit  (tb_commit),
`endif
    .bus     (bus3),
    .mem_out (mem3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with the bus idle, returns at a negedge with the DUT back in IDLE.
  task automatic access(input logic which, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic e, output int lat, output logic [31:0] m);
    logic seen;
    tb_which = which; tb_wr = wr; tb_addr = a; tb_wdata = d; tb_sel = 1'b1;
    @(posedge clk);
    lat = 0; seen = 1'b0; rd = 8'h00; e = 1'b0; m = 32'h0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack_m) seen = 1'b1;
    end
    chk("ack_seen", {63'd0, seen}, 64'd1);
    rd = rd_m;
    e  = err_m;
    m  = which ? mem3 : mem0;
    tb_sel = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {63'd0, ack_m}, 64'd0);
    @(negedge clk);
  endtask

  logic [7:0]  rd;
  logic        e;
  int          lat;
  logic [31:0] m;
  int          acks;

  initial begin
    rst_n = 1'b0; tb_sel = 1'b0; tb_which = 1'b0; tb_wr = 1'b0; tb_commit = 1'b1;
    tb_addr = 8'h00; tb_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mem0", mem0, 64'h0);
    chk("rst_mem3", mem3, 64'h0);
    chk("rst_ack", {63'd0, bus0.ack}, 64'd0);
    chk("rst_err", {63'd0, bus0.err}, 64'd0);
    chk("rst_rd", bus0.rd_data, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write/read, no wait cycles.
    access(1'b0, 1'b1, 8'd2, 8'hA5, rd, e, lat, m);
    chk("wr2_lat", lat, 64'd1);
    chk("wr2_err", {63'd0, e}, 64'd0);
    chk("wr2_rd", rd, 64'h0);
    chk("wr2_mem", m, 64'h00A5_0000);
    access(1'b0, 1'b0, 8'd2, 8'h00, rd, e, lat, m);
    chk("rd2_data", rd, 64'hA5);
    chk("rd2_err", {63'd0, e}, 64'd0);

    // Out of range and boundary addresses.
    access(1'b0, 1'b0, 8'd7, 8'h00, rd, e, lat, m);
    chk("rd7_err", {63'd0, e}, 64'd1);
    chk("rd7_rd", rd, 64'h0);
    access(1'b0, 1'b1, 8'd4, 8'hFF, rd, e, lat, m);
    chk("wr4_err", {63'd0, e}, 64'd1);
    chk("wr4_mem", m, 64'h00A5_0000);
    access(1'b0, 1'b1, 8'h84, 8'h5A, rd, e, lat, m);
    chk("wr84_err", {63'd0, e}, 64'd1);
    chk("wr84_mem", m, 64'h00A5_0000);
    access(1'b0, 1'b1, 8'd3, 8'h3E, rd, e, lat, m);
    chk("wr3_err", {63'd0, e}, 64'd0);
    chk("wr3_mem", m, 64'h3EA5_0000);

    // Three wait cycles, then an aborted write.
    access(1'b1, 1'b1, 8'd1, 8'h3C, rd, e, lat, m);
    chk("w3_lat", lat, 64'd4);
    chk("w3_mem", m, 64'h0000_3C00);
    tb_which = 1'b1; tb_wr = 1'b1; tb_addr = 8'd1; tb_wdata = 8'h77; tb_sel = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    tb_sel = 1'b0;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus3.ack) acks++;
    end
    chk("abort_acks", acks, 64'd0);
    chk("abort_mem", mem3, 64'h0000_3C00);
    access(1'b1, 1'b0, 8'd1, 8'h00, rd, e, lat, m);
    chk("abort_rd", rd, 64'h3C);

    // Held request produces a single ack; one idle cycle then a new read.
    tb_which = 1'b0; tb_wr = 1'b0; tb_addr = 8'd3; tb_sel = 1'b1;
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus0.ack) acks++;
    end
    chk("hold_acks", acks, 64'd1);
    tb_sel = 1'b0;
    @(negedge clk);
    access(1'b0, 1'b0, 8'd2, 8'h00, rd, e, lat, m);
    chk("reacc_rd", rd, 64'hA5);
    chk("reacc_lat", lat, 64'd1);

    // Reset during the wait phase of a write.
    tb_which = 1'b1; tb_wr = 1'b1; tb_addr = 8'd0; tb_wdata = 8'h55; tb_sel = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem3", mem3, 64'h0);
    chk("midrst_mem0", mem0, 64'h0);
    tb_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 8'd0, 8'h00, rd, e, lat, m);
    chk("postrst_rd", rd, 64'h0);
    chk("postrst_lat", lat, 64'd4);

`ifdef CFG_REG_SHADOW_EN
    tb_commit = 1'b0;
    access(1'b0, 1'b1, 8'd1, 8'h11, rd, e, lat, m);
    chk("shd_mem_pre", m, 64'h0);
    access(1'b0, 1'b0, 8'd1, 8'h00, rd, e, lat, m);
    chk("shd_rd", rd, 64'h11);
    chk("shd_mem_mid", mem0, 64'h0);
    tb_commit = 1'b1;
    @(negedge clk);
    chk("shd_mem_post", mem0, 64'h0000_1100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
